// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM state and op classification shared by the HI/LO scheduler
package md_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_t;
  typedef enum logic {IDLE, RUN} md_state_t;
  function automatic logic is_div(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction
  function automatic logic is_long_op(input md_op_t op);
`ifdef MD_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
  endfunction
endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E-stage HI/LO op bus, D-stage stall handshake and HI/LO read-out
interface md_sched_if;
  import md_pkg::*;
  md_op_t      op_e;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        ismu_d;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output op_e, d1, d2, ismu_d, input start, busy, stall, hi, lo);
  modport slave  (input op_e, d1, d2, ismu_d, output start, busy, stall, hi, lo);
endinterface

// File: rtl/md_core.sv
// md_core: combinational product / quotient-remainder of the latched operands, {hi,lo} packed
module md_core
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        dz
);
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] ua, ub, dv, uq, ur, q, r;
  always_comb begin
    sgn  = op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    prod = (sgn ? {{32{a[31]}}, a} : {32'd0, a}) * (sgn ? {{32{b[31]}}, b} : {32'd0, b});
    // magnitude division sidesteps the signed-overflow case; 0x80000000/-1 falls out as 0x80000000 r 0
    ua   = sgn && a[31] ? -a : a;
    ub   = sgn && b[31] ? -b : b;
    dz   = is_div(op) && b == 32'd0;
    dv   = ub == 32'd0 ? 32'd1 : ub;
    uq   = ua / dv;
    ur   = ua % dv;
    q    = sgn && (a[31] ^ b[31]) ? -uq : uq;
    r    = sgn && a[31] ? -ur : ur;
    res  = is_div(op) ? {r, q} : prod;
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle HI/LO scheduler with D-stage stall; `MD_MADD_EN adds madd/maddu/msub/msubu
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);
  md_state_t   state, nstate;
  logic [3:0]  cnt;
  md_op_t      op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [63:0] res, nxt;
  logic        dz, go, done;
  md_core u_core (.op(op_q), .a(a_q), .b(b_q), .res(res), .dz(dz));
  assign go   = state == IDLE && is_long_op(bus.op_e);
  assign done = state == RUN && cnt == 4'd0;
`ifdef MD_MADD_EN
  // accumulate against {hi,lo} as it stands at commit
  always_comb nxt = op_q inside {MD_MADD, MD_MADDU} ? {hi_q, lo_q} + res
                  : op_q inside {MD_MSUB, MD_MSUBU} ? {hi_q, lo_q} - res : res;
`else
  assign nxt = res;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : nstate;
  always_comb nstate = state == IDLE ? (go ? RUN : IDLE) : (done ? IDLE : RUN);
  always_comb begin
    bus.start = go;
    bus.busy  = state == RUN;
    bus.stall = bus.ismu_d & (go | state == RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      op_q <= MD_NONE;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (go) begin
      op_q <= bus.op_e;
      a_q  <= bus.d1;
      b_q  <= bus.d2;
      cnt  <= is_div(bus.op_e) ? 4'(DIV_CYCLES - 1) : 4'(MUL_CYCLES - 1);
    end else if (state == RUN) begin
      cnt <= done ? 4'd0 : cnt - 4'd1;
      if (done && !dz) {hi_q, lo_q} <= nxt;
    end else begin
      hi_q <= bus.op_e == MD_MTHI ? bus.d1 : hi_q;
      lo_q <= bus.op_e == MD_MTLO ? bus.d1 : lo_q;
    end
  end
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: vector table, corner sequences and random ops against a behavioural HI/LO model
module tb_md_sched;
  import md_pkg::*;
  localparam int MUL = 5;
  localparam int DIV = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  md_sched_if bus ();
  md_sched #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    md_op_t      op;
    logic [31:0] a, b;
    int          n;
    logic [31:0] h, l;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // caller sits at a negedge; returns at the negedge where busy has dropped
  task automatic run_long(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int n_exp, input logic [31:0] h_exp, input logic [31:0] l_exp,
                          input string nm);
    int n;
    bus.op_e = op; bus.d1 = a; bus.d2 = b;
    #1 chk({nm, " start"}, 64'(bus.start), 64'd1);
    @(negedge clk);
    bus.op_e = MD_NONE;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, 64'(n), 64'(n_exp));
    chk({nm, " hi"}, 64'(bus.hi), 64'(h_exp));
    chk({nm, " lo"}, 64'(bus.lo), 64'(l_exp));
  endtask

  task automatic run_short(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] h_exp, input logic [31:0] l_exp, input string nm);
    bus.op_e = op; bus.d1 = a; bus.d2 = b;
    #1 chk({nm, " start"}, 64'(bus.start), 64'd0);
    @(negedge clk);
    bus.op_e = MD_NONE;
    #1 chk({nm, " busy"}, 64'(bus.busy), 64'd0);
    chk({nm, " hi"}, 64'(bus.hi), 64'(h_exp));
    chk({nm, " lo"}, 64'(bus.lo), 64'(l_exp));
  endtask

  function automatic void model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l, output int n);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    n = 0;
    case (op)
      MD_MULT:  begin n = MUL; {h, l} = sa * sb; end
      MD_MULTU: begin n = MUL; {h, l} = ua * ub; end
      MD_DIV:   begin n = DIV; if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end end
      MD_DIVU:  begin n = DIV; if (b != 0) begin l = a / b; h = a % b; end end
      MD_MTHI:  h = a;
      MD_MTLO:  l = a;
`ifdef MD_MADD_EN
      MD_MADD:  begin n = MUL; {h, l} = {h, l} + 64'(sa * sb); end
      MD_MADDU: begin n = MUL; {h, l} = {h, l} + 64'(ua * ub); end
      MD_MSUB:  begin n = MUL; {h, l} = {h, l} - 64'(sa * sb); end
      MD_MSUBU: begin n = MUL; {h, l} = {h, l} - 64'(ua * ub); end
`endif
      default: ;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic seen;
    logic [31:0] mh, ml;
    md_op_t op;
    logic [31:0] a, b;
    tbl[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        MUL, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{MD_DIVU,  32'd100,      32'd7,        DIV, 32'd2,        32'd14};
    tbl[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        DIV, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL, 32'hFFFFFFFE, 32'h00000001};
    tbl[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, DIV, 32'd0,        32'h80000000};
    tbl[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, DIV, 32'd1,        32'hFFFFFFFD};
    bus.op_e = MD_NONE; bus.d1 = '0; bus.d2 = '0; bus.ismu_d = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset start", 64'(bus.start), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    // consecutive calls start exactly when busy drops, so these run back to back
    for (int i = 0; i < 6; i++)
      run_long(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].h, tbl[i].l, $sformatf("vec%0d", i));
    run_short(MD_MTHI, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFD, "mthi");
    run_short(MD_MTLO, 32'h0000CAFE, 32'd0, 32'h12345678, 32'h0000CAFE, "mtlo");
    run_long(MD_DIV, 32'd55, 32'd0, DIV, 32'h12345678, 32'h0000CAFE, "div0");
    bus.ismu_d = 1'b1;
    bus.op_e = MD_MULT; bus.d1 = 32'd2; bus.d2 = 32'd3;
    #1 n = 0;
    while (bus.stall && n < 20) begin
      n++;
      @(negedge clk);
      bus.op_e = MD_NONE;
      #1;
    end
    chk("stall cycles", 64'(n), 64'd6);
    chk("stall mult lo", 64'(bus.lo), 64'd6);
    bus.ismu_d = 1'b0;
    @(negedge clk);
    bus.op_e = MD_MULT; bus.d1 = 32'd4; bus.d2 = 32'd5;
    seen = 1'b0;
    repeat (8) begin
      #1 seen |= bus.stall;
      @(negedge clk);
      bus.op_e = MD_NONE;
    end
    chk("no stall without ismu_d", 64'(seen), 64'd0);
    chk("nostall mult lo", 64'(bus.lo), 64'd20);
    bus.op_e = MD_DIV; bus.d1 = 32'd100; bus.d2 = 32'd7;
    @(negedge clk);
    bus.op_e = MD_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort hi", 64'(bus.hi), 64'd0);
    chk("abort lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    run_long(MD_MULT, 32'd6, 32'd7, MUL, 32'd0, 32'd42, "post-abort mult");
    run_short(MD_MTHI, 32'd0, 32'd0, 32'd0, 32'd42, "mthi0");
    run_short(MD_MTLO, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, "mtlo1s");
`ifdef MD_MADD_EN
    run_long(MD_MADDU, 32'd1, 32'd1, MUL, 32'd1, 32'd0, "maddu");
`else
    run_short(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, "maddu off");
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mh = '0; ml = '0;
    for (int i = 0; i < 40; i++) begin
      op = md_op_t'($urandom_range(0, 10));
      a  = $urandom;
      b  = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 1) == 1 ? 32'($urandom_range(1, 20)) : $urandom);
      model(op, a, b, mh, ml, n);
      if (n > 0) run_long(op, a, b, n, mh, ml, $sformatf("rnd%0d %s", i, op.name()));
      else run_short(op, a, b, mh, ml, $sformatf("rnd%0d %s", i, op.name()));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
